// File: rtl/ucounter8_seq.sv
// rtl/ucounter8_seq.sv - command sequencer driving an external 8-bit up/down counter
//
// Commands (cmd_op): 00 LOAD preload, 01 UP, 10 DOWN, 11 WAIT. UP/DOWN/WAIT
// run for cmd_cnt cycles; cmd_arg[0] selects stop-at-terminal for UP/DOWN.
//
// Ports:
//   clk, areset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_arg, cmd_cnt    command fields
//   ctr_load_n, ctr_preld_val   counter load strobe (active low) and value
//   ctr_updown, ctr_wrapstop    counter direction (1 = up), stop-at-terminal
//   ctr_en                      counter step enable
//   ctr_overflow                counter terminal flag
//   busy, done, err             status; err qualifies the done pulse
//
// Build option: UCOUNTER8_SEQ_QUEUE_EN adds a 2-entry command FIFO so the
// next command starts straight out of DONE.

module ucounter8_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_arg,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             ctr_load_n,
  output logic [7:0]       ctr_preld_val,
  output logic             ctr_updown,
  output logic             ctr_wrapstop,
  output logic             ctr_en,
  input  logic             ctr_overflow,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DONE} state_t;

  localparam int CMD_W = CNT_W + 10;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b11;

  state_t           state, state_nx;
  logic [CNT_W-1:0] step, step_nx;
  logic             accept, start, abort;
  logic [CMD_W-1:0] in_cmd, sel_cmd;
  logic [1:0]       sel_op;
  logic [7:0]       sel_arg;
  logic [CNT_W-1:0] sel_cnt;
  logic             ready_nx, busy_nx, load_n_nx, en_nx;
  logic             updown_nx, wrapstop_nx, done_nx, err_nx;
  logic [7:0]       preld_nx;

  assign accept  = cmd_valid && cmd_ready;
  assign in_cmd  = {cmd_op, cmd_arg, cmd_cnt};
  assign sel_op  = sel_cmd[CMD_W-1 -: 2];
  assign sel_arg = sel_cmd[CNT_W +: 8];
  assign sel_cnt = sel_cmd[CNT_W-1:0];

`ifdef UCOUNTER8_SEQ_QUEUE_EN
  logic [CMD_W-1:0] q0, q1;
  logic [1:0]       q_cnt, q_cnt_nx;
  logic             can_start, push, pop;

  // Queued commands are older than the one on the port, so they start first.
  // An incoming command bypasses an empty FIFO to keep one-cycle start latency.
  always_comb begin
    can_start = (state == S_IDLE) || (state == S_DONE);
    pop       = can_start && (q_cnt != 2'd0);
    start     = can_start && ((q_cnt != 2'd0) || accept);
    push      = accept && !(can_start && (q_cnt == 2'd0));
    sel_cmd   = (q_cnt != 2'd0) ? q0 : in_cmd;
    q_cnt_nx  = q_cnt + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      q0    <= '0;
      q1    <= '0;
      q_cnt <= 2'd0;
    end else begin
      q_cnt <= q_cnt_nx;
      if (pop) begin
        q0 <= (push && (q_cnt == 2'd1)) ? in_cmd : q1;
      end else if (push) begin
        if (q_cnt == 2'd0) q0 <= in_cmd;
        else               q1 <= in_cmd;
      end
    end
  end

  assign ready_nx = (q_cnt_nx != 2'd2);
  assign busy_nx  = (state_nx != S_IDLE) || (q_cnt_nx != 2'd0);
`else
  assign start    = (state == S_IDLE) && accept;
  assign sel_cmd  = in_cmd;
  assign ready_nx = (state_nx == S_IDLE);
  assign busy_nx  = (state_nx != S_IDLE);
`endif

  // Overflow only matters while stepping with stop-at-terminal selected.
  assign abort = (state == S_RUN) && ctr_overflow && ctr_wrapstop;

  // Next state and step counter. The step counter parks at 1 on the last
  // RUN/WAIT cycle rather than wrapping through 0.
  always_comb begin
    state_nx = state;
    step_nx  = step;
    case (state)
      S_IDLE: state_nx = S_IDLE;
      S_LOAD: state_nx = S_DONE;
      S_RUN: begin
        if (abort || (step == CNT_W'(1))) state_nx = S_DONE;
        else                              step_nx  = step - CNT_W'(1);
      end
      S_WAIT: begin
        if (step == CNT_W'(1)) state_nx = S_DONE;
        else                   step_nx  = step - CNT_W'(1);
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (start) begin
      step_nx = sel_cnt;
      if (sel_op == OP_LOAD)          state_nx = S_LOAD;
      else if (sel_cnt == '0)         state_nx = S_DONE;
      else if (sel_op == OP_WAIT)     state_nx = S_WAIT;
      else                            state_nx = S_RUN;
    end
  end

  // Output values for the next cycle, registered below.
  always_comb begin
    load_n_nx   = (state_nx != S_LOAD);
    en_nx       = (state_nx == S_RUN);
    preld_nx    = ctr_preld_val;
    updown_nx   = ctr_updown;
    wrapstop_nx = ctr_wrapstop;
    if (start && (state_nx == S_LOAD)) preld_nx = sel_arg;
    if (start && (state_nx == S_RUN)) begin
      updown_nx   = (sel_op == OP_UP);
      wrapstop_nx = sel_arg[0];
    end
    done_nx = (state_nx == S_DONE);
    err_nx  = abort;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state         <= S_IDLE;
      step          <= '0;
      cmd_ready     <= 1'b1;
      ctr_load_n    <= 1'b1;
      ctr_en        <= 1'b0;
      ctr_preld_val <= 8'h00;
      ctr_updown    <= 1'b1;
      ctr_wrapstop  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nx;
      step          <= step_nx;
      cmd_ready     <= ready_nx;
      ctr_load_n    <= load_n_nx;
      ctr_en        <= en_nx;
      ctr_preld_val <= preld_nx;
      ctr_updown    <= updown_nx;
      ctr_wrapstop  <= wrapstop_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      err           <= err_nx;
    end
  end

endmodule

// File: tb/tb_ucounter8_seq.sv
// tb/tb_ucounter8_seq.sv - directed scoreboard bench for ucounter8_seq

module tb_ucounter8_seq;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             areset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [7:0]       cmd_arg = 8'h00;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             ctr_load_n;
  logic [7:0]       ctr_preld_val;
  logic             ctr_updown;
  logic             ctr_wrapstop;
  logic             ctr_en;
  logic             ctr_overflow = 1'b0;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  ucounter8_seq #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .areset       (areset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .cmd_cnt      (cmd_cnt),
    .ctr_load_n   (ctr_load_n),
    .ctr_preld_val(ctr_preld_val),
    .ctr_updown   (ctr_updown),
    .ctr_wrapstop (ctr_wrapstop),
    .ctr_en       (ctr_en),
    .ctr_overflow (ctr_overflow),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  typedef struct {
    int         len;
    int         en;
    bit         err;
    bit         is_load;
    bit         is_run;
    logic [7:0] preld;
    bit         updown;
    bit         wrapstop;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   done_t[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   len_cnt = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [7:0] arg,
                                 input int cnt, input int abort_at);
    exp_t e;
    e.len = 0; e.en = 0; e.err = 0; e.is_run = 0;
    e.is_load  = (op == 2'b00);
    e.preld    = arg;
    e.updown   = (op == 2'b01);
    e.wrapstop = arg[0];
    if (op == 2'b00) e.len = 1;
    else if (cnt == 0) e.len = 0;
    else if (op == 2'b11) e.len = cnt;
    else begin
      e.is_run = 1;
      if (arg[0] && abort_at > 0 && abort_at <= cnt) begin
        e.len = abort_at;
        e.err = 1;
      end else begin
        e.len = cnt;
      end
      e.en = e.len;
    end
    return e;
  endfunction

  // Drive a command at posedge+1, wait for ready, log the expectation, hand
  // it over on the next edge. Returns at posedge+1 of the first exec cycle.
  task automatic send(input logic [1:0] op, input logic [7:0] arg,
                      input int cnt, input int abort_at);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_cnt   = CNT_W'(cnt);
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", cmd_ready, 1);
    sb.push_back(model(op, arg, cnt, abort_at));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load_n"},   ctr_load_n, 1);
    chk({tag, "_en"},       ctr_en, 0);
    chk({tag, "_preld"},    ctr_preld_val, 0);
    chk({tag, "_updown"},   ctr_updown, 1);
    chk({tag, "_wrapstop"}, ctr_wrapstop, 0);
    chk({tag, "_done"},     done, 0);
    chk({tag, "_err"},      err, 0);
    chk({tag, "_busy"},     busy, 0);
  endtask

  // Output monitor: counts enable and execution cycles per command and
  // checks them against the scoreboard head when done pulses.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (areset) begin
        en_cnt  = 0;
        len_cnt = 0;
      end else begin
        chk("load_en_exclusive", ctr_en && !ctr_load_n, 0);
        if (!done) chk("err_without_done", err, 0);
        if (ctr_en) begin
          en_cnt++;
          if (sb.size() > 0 && sb[0].is_run) begin
            chk("run_updown", ctr_updown, sb[0].updown);
            chk("run_wrapstop", ctr_wrapstop, sb[0].wrapstop);
          end
        end
        if (!ctr_load_n && sb.size() > 0 && sb[0].is_load)
          chk("load_value", ctr_preld_val, sb[0].preld);
        if (busy && !done) len_cnt++;
        if (done) begin
          done_t.push_back(cyc);
          chk("done_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("cmd_len", len_cnt, mon_e.len);
            chk("cmd_en_cycles", en_cnt, mon_e.en);
            chk("cmd_err", err, mon_e.err);
          end
          en_cnt  = 0;
          len_cnt = 0;
        end
      end
    end
  end

  initial begin
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    areset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);
    @(posedge clk); #1;

    // LOAD F8: strobe in k+1, done in k+2
    send(2'b00, 8'hF8, 0, 0);
    chk("load_strobe", ctr_load_n, 0);
    chk("load_preld", ctr_preld_val, 8'hF8);
    chk("load_no_en", ctr_en, 0);
    @(posedge clk); #1;
    chk("load_done", done, 1);
    chk("load_err", err, 0);
    wait_idle();

    // UP 5, wrap mode: an overflow pulse must not shorten it
    send(2'b01, 8'h00, 5, 0);
    chk("up_en_first", ctr_en, 1);
    @(posedge clk); #1;
    ctr_overflow = 1'b1;
    @(posedge clk); #1;
    ctr_overflow = 1'b0;
    wait_idle();
    chk("hold_updown_up", ctr_updown, 1);
    chk("hold_preld", ctr_preld_val, 8'hF8);

    // DOWN 15, stop mode, overflow in RUN cycle 4
    send(2'b10, 8'h01, 15, 4);
    repeat (3) begin @(posedge clk); #1; end
    ctr_overflow = 1'b1;
    @(posedge clk); #1;
    ctr_overflow = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_err", err, 1);
    chk("abort_en_off", ctr_en, 0);
    wait_idle();
    chk("hold_updown_down", ctr_updown, 0);
    chk("hold_wrapstop", ctr_wrapstop, 1);

    // WAIT 0 completes at once; WAIT 3 ignores overflow
    send(2'b11, 8'hFF, 0, 0);
    chk("wait0_done", done, 1);
    chk("wait0_err", err, 0);
    wait_idle();
    send(2'b11, 8'h01, 3, 0);
    chk("wait_no_en", ctr_en, 0);
    chk("wait_no_load", ctr_load_n, 1);
    ctr_overflow = 1'b1;
    @(posedge clk); #1;
    ctr_overflow = 1'b0;
    wait_idle();
    chk("hold_wrapstop_wait", ctr_wrapstop, 1);

    // Reset in RUN cycle 3 of UP 10
    send(2'b01, 8'h00, 10, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("run_before_reset", ctr_en, 1);
    areset = 1'b1;
    #1;
    chk_reset_outputs("midrun_reset");
    sb.delete();
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    chk("ready_after_midrun_reset", cmd_ready, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("no_done_after_reset", done, 0);
    end
    send(2'b00, 8'h5A, 0, 0);
    wait_idle();

`ifdef UCOUNTER8_SEQ_QUEUE_EN
    // Back-to-back queued commands: done spacing = next command length + 1
    done_t.delete();
    send(2'b00, 8'h00, 0, 0);
    send(2'b01, 8'h00, 3, 0);
    send(2'b10, 8'h00, 2, 0);
    wait_idle();
    chk("queue_done_count", done_t.size(), 3);
    if (done_t.size() == 3) begin
      chk("queue_gap_up", done_t[1] - done_t[0], 4);
      chk("queue_gap_down", done_t[2] - done_t[1], 3);
    end
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
